rx_deserializer: RTL

RX_DESERIALIZER -- requirements
Module: rx_deserializer

---
 rtl/rx_deserializer_if.sv | 29 ++
 rtl/rx_deserializer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rx_deserializer_if.sv
// Bundle of serial-side strobes, consumer handshake and status flags for
// rx_deserializer. The master side (bit-timing logic plus consumer) drives
// the strobes and data_ready; the slave side (the deserializer) returns the
// assembled word, its flags and the FSM state for debug visibility.
interface rx_deserializer_if #(
  parameter int WORD_LENGTH = 8
);
  logic                   SerialDataIn;
  logic                   frame_start;
  logic                   sample_en;
  logic                   data_ready;
  logic                   err_clr;
  logic [WORD_LENGTH-1:0] data_out;
  logic                   data_valid;
  logic                   parity_err;
  logic                   overrun;
  logic                   busy;
  logic [1:0]             state_dbg;

  modport master (
    output SerialDataIn, frame_start, sample_en, data_ready, err_clr,
    input  data_out, data_valid, parity_err, overrun, busy, state_dbg
  );

  modport slave (
    input  SerialDataIn, frame_start, sample_en, data_ready, err_clr,
    output data_out, data_valid, parity_err, overrun, busy, state_dbg
  );
endinterface

// File: rtl/rx_deserializer.sv
// Serial-to-parallel receiver core. A start-bit detector pulses frame_start,
// a bit-timing block pulses sample_en at each bit centre; this block shifts
// the line value in, optionally checks one trailing parity bit and presents
// the finished word to a consumer.
//
// Output handshake: data_valid=1 means data_out/parity_err hold a word that
// has not yet been taken. The word is taken on a rising edge where
// data_valid=1 and data_ready=1. data_valid never drops without that
// transfer, except through reset. A new word arriving while the old one is
// still untaken replaces it and sets the sticky overrun flag; a new word
// arriving on the very edge the old one is taken just replaces it.
module rx_deserializer #(
  parameter int WORD_LENGTH = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int MSB_FIRST   = 0
) (
  input  logic             clk,
  input  logic             reset,
  rx_deserializer_if.slave bus
);

  localparam int W  = WORD_LENGTH;
  // Counter indexes data bits 0..W-1, so it needs to hold W-1.
  localparam int CW = $clog2(W);

  localparam logic [CW-1:0] LAST_BIT   = CW'(W - 1);
  localparam logic          HAS_PARITY = (PARITY_EN != 0);
  localparam logic          ODD        = (PARITY_ODD != 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_cnt_next;
  logic [W-1:0]  sr;
  logic [W-1:0]  sr_next;
  logic [W-1:0]  sr_shifted;

  logic          complete;
  logic [W-1:0]  word_done;
  logic          perr_done;
  logic          overrun_set;

  logic [W-1:0]  data_q;
  logic          valid_q;
  logic          perr_q;
  logic          overrun_q;

  // Shift register with the current line value inserted at the end that
  // matches the transmit order.
  always_comb begin
    sr_shifted = sr;
    if (MSB_FIRST != 0) begin
      sr_shifted = {sr[W-2:0], bus.SerialDataIn};
    end else begin
      sr_shifted = {bus.SerialDataIn, sr[W-1:1]};
    end
  end

  // Frame sequencing: frame_start always restarts the frame and swallows any
  // coincident sample; otherwise samples advance DATA and PARITY.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    sr_next      = sr;
    complete     = 1'b0;
    word_done    = sr;
    perr_done    = 1'b0;
    if (bus.frame_start) begin
      sr_next      = '0;
      bit_cnt_next = '0;
      state_next   = DATA;
    end else if (bus.sample_en) begin
      case (state)
        DATA: begin
          sr_next = sr_shifted;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_next = '0;
            if (HAS_PARITY) begin
              state_next = PARITY;
            end else begin
              complete   = 1'b1;
              word_done  = sr_shifted;
              state_next = IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt + CW'(1);
          end
        end
        PARITY: begin
          // Expected parity bit is the data XOR, inverted for odd parity.
          complete   = 1'b1;
          word_done  = sr;
          perr_done  = HAS_PARITY & (bus.SerialDataIn ^ (^sr) ^ ODD);
          state_next = IDLE;
        end
        default: begin
          // IDLE ignores samples until the next frame_start.
        end
      endcase
    end
  end

  // A finished word lands on top of one that the consumer is not taking now.
  assign overrun_set = complete & valid_q & ~bus.data_ready;

  // Frame-progress registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sr      <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      sr      <= sr_next;
    end
  end

  // Output word, its valid/parity flags and the handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
    end else if (complete) begin
      data_q  <= word_done;
      valid_q <= 1'b1;
      perr_q  <= perr_done;
    end else if (valid_q && bus.data_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else if (overrun_set) begin
      overrun_q <= 1'b1;
    end else if (bus.err_clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state != IDLE);
  assign bus.state_dbg  = state;

endmodule
